// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl
// ---------------
// Initiator end of an 8-slave shared bus. It takes one CPU load/store at a
// time and decodes the top three word-address bits into one of eight chip
// selects. It drives the registered address, direction, write data and
// address strobe for the whole ACCESS phase. It completes on s_ready, or on a
// timeout that reports a bus error. All outputs come straight from registers.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req        CPU request, sampled only while idle
//   rw         1 = write, 0 = read
//   addr       CPU word address
//   wr_data    CPU store data
//   busy       high while a transaction is outstanding
//   ack        one-cycle completion pulse
//   rd_data    read result, valid with ack, held until the next read completes
//   bus_err    one-cycle pulse with ack when no slave answered in time
//   s_addr     registered bus address
//   s_as       address strobe, high for the whole ACCESS phase
//   s_rw       registered bus direction
//   s_wr_data  registered bus write data
//   s0_cs..s7_cs  chip selects, one at `CS_ENABLE during ACCESS, else inactive
//   s_ready    muxed slave ready
//   s_rd_data  muxed slave read data
//
// TIMEOUT must be >= 1 and must fit in CNT_W bits.

`ifndef CS_ENABLE
`define CS_ENABLE 1'b1
`endif

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module bus_master_ctrl #(
    parameter int DATA_W  = `DATA_WIDTH,
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              bus_err,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_as,
    output logic              s_rw,
    output logic [DATA_W-1:0] s_wr_data,
    output logic              s0_cs,
    output logic              s1_cs,
    output logic              s2_cs,
    output logic              s3_cs,
    output logic              s4_cs,
    output logic              s5_cs,
    output logic              s6_cs,
    output logic              s7_cs,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rd_data
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] CS_IDLE  = {8{~`CS_ENABLE}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              busy_reg, busy_next;
    logic              ack_reg, ack_next;
    logic              bus_err_reg, bus_err_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic [ADDR_W-1:0] s_addr_reg, s_addr_next;
    logic              s_as_reg, s_as_next;
    logic              s_rw_reg, s_rw_next;
    logic [DATA_W-1:0] s_wr_data_reg, s_wr_data_next;
    logic [7:0]        cs_reg, cs_next;

    // One-of-eight decode of the slave select field of the incoming address.
    logic [2:0] sel;
    logic [7:0] cs_decode;

    assign sel = addr[ADDR_W-1 -: 3];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cs_decode
            assign cs_decode[gi] = (sel == 3'(gi)) ? `CS_ENABLE : ~`CS_ENABLE;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            bus_err_reg   <= 1'b0;
            rd_data_reg   <= '0;
            s_addr_reg    <= '0;
            s_as_reg      <= 1'b0;
            s_rw_reg      <= 1'b0;
            s_wr_data_reg <= '0;
            cs_reg        <= CS_IDLE;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            busy_reg      <= busy_next;
            ack_reg       <= ack_next;
            bus_err_reg   <= bus_err_next;
            rd_data_reg   <= rd_data_next;
            s_addr_reg    <= s_addr_next;
            s_as_reg      <= s_as_next;
            s_rw_reg      <= s_rw_next;
            s_wr_data_reg <= s_wr_data_next;
            cs_reg        <= cs_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        busy_next      = busy_reg;
        ack_next       = 1'b0;
        bus_err_next   = 1'b0;
        rd_data_next   = rd_data_reg;
        s_addr_next    = s_addr_reg;
        s_as_next      = s_as_reg;
        s_rw_next      = s_rw_reg;
        s_wr_data_next = s_wr_data_reg;
        cs_next        = cs_reg;

        case (state_reg)
            IDLE: begin
                // Bus address/data keep their last values between transfers.
                busy_next = 1'b0;
                s_as_next = 1'b0;
                cs_next   = CS_IDLE;
                if (req) begin
                    s_addr_next    = addr;
                    s_rw_next      = rw;
                    s_wr_data_next = wr_data;
                    s_as_next      = 1'b1;
                    cs_next        = cs_decode;
                    busy_next      = 1'b1;
                    cnt_next       = '0;
                    state_next     = ACCESS;
                end
            end
            ACCESS: begin
                // A ready on the final timeout edge still counts as success.
                if (s_ready) begin
                    if (!s_rw_reg) begin
                        rd_data_next = s_rd_data;
                    end
                    ack_next   = 1'b1;
                    busy_next  = 1'b0;
                    s_as_next  = 1'b0;
                    cs_next    = CS_IDLE;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    ack_next     = 1'b1;
                    bus_err_next = 1'b1;
                    busy_next    = 1'b0;
                    s_as_next    = 1'b0;
                    cs_next      = CS_IDLE;
                    state_next   = IDLE;
                end else if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = busy_reg;
    assign ack       = ack_reg;
    assign bus_err   = bus_err_reg;
    assign rd_data   = rd_data_reg;
    assign s_addr    = s_addr_reg;
    assign s_as      = s_as_reg;
    assign s_rw      = s_rw_reg;
    assign s_wr_data = s_wr_data_reg;
    assign s0_cs     = cs_reg[0];
    assign s1_cs     = cs_reg[1];
    assign s2_cs     = cs_reg[2];
    assign s3_cs     = cs_reg[3];
    assign s4_cs     = cs_reg[4];
    assign s5_cs     = cs_reg[5];
    assign s6_cs     = cs_reg[6];
    assign s7_cs     = cs_reg[7];

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Testbench for bus_master_ctrl: directed cases followed by randomized
// transactions. Each transaction is described by its slave response delay,
// and the expected ACCESS length, error flag and read data follow from that
// delay with plain arithmetic.

`ifndef CS_ENABLE
`define CS_ENABLE 1'b1
`endif

module tb_bus_master_ctrl;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int TO = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          ack;
    logic [DW-1:0] rd_data;
    logic          bus_err;
    logic [AW-1:0] s_addr;
    logic          s_as;
    logic          s_rw;
    logic [DW-1:0] s_wr_data;
    logic          s0_cs, s1_cs, s2_cs, s3_cs, s4_cs, s5_cs, s6_cs, s7_cs;
    logic          s_ready;
    logic [DW-1:0] s_rd_data;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_rd;

    always #5 clk = ~clk;

    bus_master_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .rw       (rw),
        .addr     (addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .ack      (ack),
        .rd_data  (rd_data),
        .bus_err  (bus_err),
        .s_addr   (s_addr),
        .s_as     (s_as),
        .s_rw     (s_rw),
        .s_wr_data(s_wr_data),
        .s0_cs    (s0_cs),
        .s1_cs    (s1_cs),
        .s2_cs    (s2_cs),
        .s3_cs    (s3_cs),
        .s4_cs    (s4_cs),
        .s5_cs    (s5_cs),
        .s6_cs    (s6_cs),
        .s7_cs    (s7_cs),
        .s_ready  (s_ready),
        .s_rd_data(s_rd_data)
    );

    logic [7:0] cs_bus;
    assign cs_bus = {s7_cs, s6_cs, s5_cs, s4_cs, s3_cs, s2_cs, s1_cs, s0_cs};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected chip-select vector: slave index is the address divided by 2^(AW-3).
    function automatic logic [7:0] cs_for(input logic [AW-1:0] a, input bit active);
        logic [7:0] v;
        int         s;
        s = int'(a / (AW'(1) << (AW - 3)));
        for (int i = 0; i < 8; i++) begin
            v[i] = (active && i == s) ? `CS_ENABLE : ~`CS_ENABLE;
        end
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, ".ack"}, 64'(ack), 64'(0));
        check_eq({tag, ".busy"}, 64'(busy), 64'(0));
        check_eq({tag, ".s_as"}, 64'(s_as), 64'(0));
        check_eq({tag, ".cs"}, 64'(cs_bus), 64'(cs_for('0, 1'b0)));
        check_eq({tag, ".rd_data"}, 64'(rd_data), 64'(exp_rd));
    endtask

    // Idle cycles with s_ready noise, which must be ignored outside ACCESS.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req       = 1'b0;
            s_ready   = 1'($urandom);
            s_rd_data = $urandom;
            @(posedge clk);
            #1;
            @(negedge clk);
            check_idle("idle");
        end
        s_ready = 1'b0;
    endtask

    // One transaction. The slave answers on ACCESS cycle d (0-based); a delay
    // of TO or more never answers. Returns in the ack cycle, after its checks,
    // so an immediate further call issues a back-to-back request.
    task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rdv, input int d, input bit noise);
        int n;
        bit ok;
        ok = (d < TO);
        n  = ok ? d + 1 : TO;
        req     = 1'b1;
        addr    = a;
        rw      = w;
        wr_data = wd;
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            s_ready   = (k == d);
            s_rd_data = (k == d) ? rdv : $urandom;
            if (noise) begin
                req     = 1'($urandom);
                addr    = AW'($urandom);
                rw      = 1'($urandom);
                wr_data = $urandom;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            check_eq("acc.busy", 64'(busy), 64'(1));
            check_eq("acc.s_as", 64'(s_as), 64'(1));
            check_eq("acc.ack", 64'(ack), 64'(0));
            check_eq("acc.cs", 64'(cs_bus), 64'(cs_for(a, 1'b1)));
            check_eq("acc.s_addr", 64'(s_addr), 64'(a));
            check_eq("acc.s_rw", 64'(s_rw), 64'(w));
            check_eq("acc.s_wr_data", 64'(s_wr_data), 64'(wd));
            @(posedge clk);
            #1;
        end
        req     = 1'b0;
        s_ready = 1'b0;
        if (ok && !w) exp_rd = rdv;
        @(negedge clk);
        check_eq("done.ack", 64'(ack), 64'(1));
        check_eq("done.bus_err", 64'(bus_err), 64'(!ok));
        check_eq("done.busy", 64'(busy), 64'(0));
        check_eq("done.s_as", 64'(s_as), 64'(0));
        check_eq("done.cs", 64'(cs_bus), 64'(cs_for('0, 1'b0)));
        check_eq("done.rd_data", 64'(rd_data), 64'(exp_rd));
        $display("txn addr=%h rw=%0d delay=%0d -> ack=%0d err=%0d rd=%h",
                 a, w, d, ack, bus_err, rd_data);
    endtask

    initial begin
        reset     = 1'b0;
        req       = 1'b0;
        rw        = 1'b0;
        addr      = '0;
        wr_data   = '0;
        s_ready   = 1'b0;
        s_rd_data = '0;
        exp_rd    = '0;

        // Reset held for three cycles, then released away from the edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("rst");
        check_eq("rst.s_addr", 64'(s_addr), 64'(0));
        check_eq("rst.bus_err", 64'(bus_err), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        check_idle("rst_rel");

        // Read from slave 2 (address bits [29:27] = 3'b010), ready at once.
        run_txn(30'h1000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        idle_cycles(2);

        // Write to slave 7, slave answers on the 6th ACCESS cycle.
        run_txn(30'h3800_0004, 1'b1, 32'h1234_5678, 32'hAAAA_5555, 5, 1'b0);
        idle_cycles(1);

        // Timeout: no answer at all.
        run_txn(30'h0800_0100, 1'b0, 32'h0, 32'h0BAD_0BAD, TO + 3, 1'b0);
        idle_cycles(1);

        // Ready on the very cycle the timeout would fire: success wins.
        run_txn(30'h2800_0020, 1'b0, 32'h0, 32'hC011_1DE5, TO - 1, 1'b0);
        idle_cycles(1);

        // Back-to-back requests with req pulses during ACCESS.
        run_txn(30'h1800_0008, 1'b0, 32'h0, 32'h1111_2222, 2, 1'b1);
        run_txn(30'h3000_000C, 1'b1, 32'h5A5A_A5A5, 32'h3333_4444, 0, 1'b1);
        run_txn(30'h0000_0003, 1'b0, 32'h0, 32'h5555_6666, 1, 1'b0);
        idle_cycles(1);

        // Reset in the middle of ACCESS: bus dropped at once, no ack.
        req  = 1'b1;
        addr = 30'h2000_0040;
        rw   = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check_eq("mid.s_as", 64'(s_as), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        exp_rd = '0;
        check_idle("mid_rst");
        repeat (2) begin
            @(negedge clk);
            check_eq("mid_rst.ack", 64'(ack), 64'(0));
        end
        reset = 1'b1;
        idle_cycles(2);

        // Randomized transactions, including back-to-back chains.
        for (int t = 0; t < 40; t++) begin
            run_txn(AW'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom_range(0, TO + 2), 1'($urandom));
            if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
